// File: rtl/exe_div.sv
// Iterative MIPS32 DIV/DIVU unit for the EXE stage: one restoring step per cycle,
// result presented as {HI=remainder, LO=quotient} with a one-cycle ready pulse.
module exe_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 annul,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   hilo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 sgn_a_q, sgn_a_d;
    logic                 sgn_b_q, sgn_b_d;
    logic                 sop_q, sop_d;
    logic [2*WIDTH-1:0]   hilo_q, hilo_d;
    logic                 busy_q;
    logic                 ready_q;

    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH:0]       rem_nx_s;
    logic [WIDTH-1:0]     quo_nx_s;

    // Two's complement negate of x when en is set, otherwise pass-through.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
        logic [WIDTH-1:0] r;
        if (en) begin
            r = (~x) + W_ONE;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // One restoring step: quotient register doubles as the dividend shift source.
    always_comb begin
        rem_sh_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dvsr_q};
        rem_nx_s = rem_sh_s;
        quo_nx_s = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff_s[WIDTH]) begin
            rem_nx_s = diff_s;
            quo_nx_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx_s = rem_sh_s;
            quo_nx_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and datapath load logic; hilo is only written on entry to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        sgn_a_d = sgn_a_q;
        sgn_b_d = sgn_b_q;
        sop_d   = sop_q;
        hilo_d  = hilo_q;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    if (divisor == W_ZERO) begin
                        state_d = DONE;
                        hilo_d  = {dividend, {WIDTH{1'b1}}};
                    end else begin
                        state_d = CALC;
                        rem_d   = {(WIDTH+1){1'b0}};
                        quo_d   = cond_neg(dividend, signed_op & dividend[WIDTH-1]);
                        dvsr_d  = cond_neg(divisor, signed_op & divisor[WIDTH-1]);
                        sgn_a_d = dividend[WIDTH-1];
                        sgn_b_d = divisor[WIDTH-1];
                        sop_d   = signed_op;
                        cnt_d   = CNT_MAX;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    if (cnt_q == CNT_ZERO) begin
                        state_d = DONE;
                        hilo_d  = {cond_neg(rem_nx_s[WIDTH-1:0], sop_q & sgn_a_q),
                                   cond_neg(quo_nx_s, sop_q & (sgn_a_q ^ sgn_b_q))};
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            rem_q   <= {(WIDTH+1){1'b0}};
            quo_q   <= W_ZERO;
            dvsr_q  <= W_ZERO;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            sop_q   <= 1'b0;
            hilo_q  <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            sgn_a_q <= sgn_a_d;
            sgn_b_q <= sgn_b_d;
            sop_q   <= sop_d;
            hilo_q  <= hilo_d;
            busy_q  <= (state_d == CALC);
            ready_q <= (state_d == DONE);
        end
    end

    // Stall must rise in the same cycle start is seen, so it cannot be registered.
    always_comb begin
        stall_req = 1'b0;
        if (state_q == CALC) begin
            stall_req = 1'b1;
        end else if ((state_q == IDLE) && start && !annul) begin
            stall_req = 1'b1;
        end else begin
            stall_req = 1'b0;
        end
    end

    assign busy  = busy_q;
    assign ready = ready_q;
    assign hilo  = hilo_q;

endmodule

// File: tb/tb_exe_div.sv
// Self-checking bench for exe_div: directed spec cases plus randomized divides
// compared against a plain-arithmetic reference model.
module tb_exe_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stall_req;
    logic        busy;
    logic        ready;
    logic [63:0] hilo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exe_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .annul     (annul),
        .stall_req (stall_req),
        .busy      (busy),
        .ready     (ready),
        .hilo      (hilo)
    );

    // Reference: truncating division, remainder follows dividend sign, mod 2^32.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint      sa;
        longint      sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Start a divide in cycle 0 and run until ready or the cycle budget expires.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int rdy_cyc, output int stall_cnt, output bit busy_seen,
                          output logic [63:0] res);
        rdy_cyc   = -1;
        stall_cnt = 0;
        busy_seen = 1'b0;
        res       = 64'd0;
        @(posedge clk); #1;
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall_req) stall_cnt++;
            if (busy) busy_seen = 1'b1;
            if (ready) begin
                rdy_cyc = c;
                res     = hilo;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
        dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({hilo, ready, busy, stall_req} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_during: hilo=%h r=%b b=%b s=%b required all 0", hilo, ready, busy, stall_req);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({hilo, ready, busy, stall_req} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_after: hilo=%h r=%b b=%b s=%b required all 0", hilo, ready, busy, stall_req);
        end
    endtask

    task automatic test_directed();
        logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ta [5] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [5] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [63:0] te [5] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                {32'd1, 32'hFFFF_FFFD}, {32'd0, 32'h8000_0000},
                                {32'h7FFF_FFFF, 32'd1}};
        int rc, sc; bit bs; logic [63:0] res;
        for (int i = 0; i < 5; i++) begin
            do_div(ts[i], ta[i], tb[i], rc, sc, bs, res);
            n_tests++;
            if (res !== te[i]) begin
                n_fail++;
                $display("FAIL directed_hilo[%0d]: got %h required %h", i, res, te[i]);
            end
            n_tests++;
            if (rc != 33 || sc != 33 || bs !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: ready_cyc=%0d stall=%0d busy=%b required 33/33/1", i, rc, sc, bs);
            end
        end
    endtask

    task automatic test_div_zero();
        int rc, sc; bit bs; logic [63:0] res;
        do_div(1'b0, 32'h0000_1234, 32'd0, rc, sc, bs, res);
        n_tests++;
        if (res !== {32'h0000_1234, 32'hFFFF_FFFF} || rc != 1 || sc != 1 || bs !== 1'b0) begin
            n_fail++;
            $display("FAIL div_zero_u: hilo=%h cyc=%0d stall=%0d busy=%b required 00001234ffffffff/1/1/0", res, rc, sc, bs);
        end
        do_div(1'b1, 32'hFFFF_FF00, 32'd0, rc, sc, bs, res);
        n_tests++;
        if (res !== {32'hFFFF_FF00, 32'hFFFF_FFFF} || rc != 1 || bs !== 1'b0) begin
            n_fail++;
            $display("FAIL div_zero_s: hilo=%h cyc=%0d busy=%b required ffffff00ffffffff/1/0", res, rc, bs);
        end
    endtask

    task automatic test_annul();
        int rc, sc; bit bs; logic [63:0] prior; logic [63:0] res;
        int bad_rdy = 0; int bad_hilo = 0; int rcyc = -1;
        do_div(1'b0, 32'd100, 32'd7, rc, sc, bs, prior);
        // start and annul together: nothing should begin
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; signed_op = 1'b0; dividend = 32'd5; divisor = 32'd1;
        @(negedge clk);
        n_tests++;
        if (stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_vs_start_stall: got %b required 0", stall_req);
        end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_vs_start_busy: got %b required 0", busy);
        end
        // annul in cycle 10 of a running DIVU
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 10) annul = 1'b1;
            @(negedge clk);
            if (ready) bad_rdy++;
            if (hilo !== prior) bad_hilo++;
        end
        @(posedge clk); #1;
        annul = 1'b0; dividend = 32'd50; divisor = 32'd6;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0 || hilo !== prior || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL annul_cycle11: busy=%b ready=%b hilo=%h stall=%b required 0/0/%h/1", busy, ready, hilo, stall_req, prior);
        end
        for (int c = 11; c < 100; c++) begin
            if (ready) begin
                rcyc = c;
                res  = hilo;
                break;
            end
            if (hilo !== prior) bad_hilo++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++;
        if (bad_rdy != 0 || bad_hilo != 0) begin
            n_fail++;
            $display("FAIL annul_no_effect: spurious_ready=%0d hilo_changes=%0d required 0/0", bad_rdy, bad_hilo);
        end
        n_tests++;
        if (rcyc != 44 || res !== ref_div(1'b0, 32'd50, 32'd6)) begin
            n_fail++;
            $display("FAIL annul_restart: cyc=%0d hilo=%h required 44/%h", rcyc, res, ref_div(1'b0, 32'd50, 32'd6));
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int rc [2] = '{-1, -1};
        logic [63:0] rv [2] = '{64'd0, 64'd0};
        logic [63:0] mid = 64'd0;
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd9; divisor = 32'd3;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ready) begin
                if (k < 2) begin
                    rc[k] = c;
                    rv[k] = hilo;
                end
                k++;
            end
            if (c == 50) mid = hilo;
            @(posedge clk); #1;
            if (k == 1) begin
                dividend = 32'd10; divisor = 32'd4;
            end
            if (k >= 2) start = 1'b0;
        end
        start = 1'b0;
        n_tests++;
        if (k != 2 || rc[0] != 33 || rv[0] !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL b2b_first: readys=%0d cyc=%0d hilo=%h required 2/33/%h", k, rc[0], rv[0], {32'd0, 32'd3});
        end
        n_tests++;
        if (rc[1] != 67 || rv[1] !== {32'd2, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_second: cyc=%0d hilo=%h required 67/%h", rc[1], rv[1], {32'd2, 32'd2});
        end
        n_tests++;
        if (mid !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL b2b_hilo_hold: got %h required %h", mid, {32'd0, 32'd3});
        end
    endtask

    task automatic test_random();
        int rc, sc; bit bs; logic [63:0] res; logic [63:0] exp;
        logic s; logic [31:0] a; logic [31:0] b; int mode;
        for (int i = 0; i < 60; i++) begin
            s    = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                4: b = 32'h8000_0000 | b;
                default: ;
            endcase
            exp = ref_div(s, a, b);
            do_div(s, a, b, rc, sc, bs, res);
            n_tests++;
            if (res !== exp || rc != ((b == 32'd0) ? 1 : 33)) begin
                n_fail++;
                $display("FAIL random[%0d] s=%b %h/%h: hilo=%h cyc=%0d required %h/%0d",
                         i, s, a, b, res, rc, exp, (b == 32'd0) ? 1 : 33);
            end
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        @(posedge clk); #1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd12345; divisor = 32'd17;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0;
        #1;
        n_tests++;
        if ({hilo, ready, busy, stall_req} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid: hilo=%h r=%b b=%b s=%b required all 0", hilo, ready, busy, stall_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready || busy) spurious++;
        end
        n_tests++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL reset_mid_after: spurious ready/busy cycles=%0d required 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_annul();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
